// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 5-stage MIPS core:
//   - opcode / funct constants used by ID-stage decode
//   - state encoding of the pipeline sequencing controller
//   - the register-read decode rule, shared with the forwarding unit so both
//     blocks always agree on which source registers an instruction reads
// -----------------------------------------------------------------------------
package mips_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (inst[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;

  // Sequencing controller states
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,  // normal flow, hazards evaluated every cycle
    ST_BUBBLE  = 2'd1,  // second bubble of a two-bubble load-use stall
    ST_MEMWAIT = 2'd2   // data memory has not completed the MEM access
  } hz_state_e;

  // Source registers read in ID. A register that is not read is reported
  // as $0, which can never match a hazard, so callers need no extra flags.
  typedef struct packed {
    logic [4:0] read_a;  // rs slot
    logic [4:0] read_b;  // rt slot
  } reg_reads_t;

  function automatic reg_reads_t decode_reg_reads(
    input logic [5:0] opcode,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [5:0] funct
  );
    reg_reads_t rr;
    logic       is_r;
    logic       reads_rs;
    logic       reads_rt;
    is_r     = (opcode == OP_RTYPE);
    // Shifts take their operand from rt and the amount from shamt; J/JAL
    // carry a target in the rs bits.
    reads_rs = !((is_r && (funct == FN_SLL || funct == FN_SRL)) ||
                 opcode == OP_J || opcode == OP_JAL);
    // JR is R-type but only reads rs; SW reads rt as store data.
    reads_rt = (is_r && funct != FN_JR) ||
               opcode == OP_SW || opcode == OP_BEQ || opcode == OP_BNE;
    rr.read_a = reads_rs ? rs : 5'd0;
    rr.read_b = reads_rt ? rt : 5'd0;
    return rr;
  endfunction

  // Instructions whose operands are consumed in ID (compare / jump target)
  // and therefore need one more bubble behind a load than ALU consumers.
  function automatic logic is_branch_or_jr(
    input logic [5:0] opcode,
    input logic [5:0] funct
  );
    return (opcode == OP_BEQ) || (opcode == OP_BNE) ||
           (opcode == OP_RTYPE && funct == FN_JR);
  endfunction

endpackage

// File: rtl/id_read_decode.sv
// -----------------------------------------------------------------------------
// id_read_decode
// Extracts the source registers actually read by the instruction in ID and
// flags branch/JR instructions (operands needed in ID).
// Ports:
//   ID_inst       in  32  instruction currently in ID
//   read_a        out 5   rs if read, else $0
//   read_b        out 5   rt if read, else $0
//   branch_or_jr  out 1   instruction is BEQ, BNE or JR
// -----------------------------------------------------------------------------
module id_read_decode
  import mips_pkg::*;
(
  input  logic [31:0] ID_inst,
  output logic [4:0]  read_a,
  output logic [4:0]  read_b,
  output logic        branch_or_jr
);

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] funct;
  reg_reads_t rr;
  logic       unused_imm;

  assign opcode = ID_inst[31:26];
  assign rs     = ID_inst[25:21];
  assign rt     = ID_inst[20:16];
  assign funct  = ID_inst[5:0];

  // rd/shamt/immediate bits play no part in hazard detection.
  assign unused_imm = ^ID_inst[15:6];

  assign rr           = decode_reg_reads(opcode, rs, rt, funct);
  assign read_a       = rr.read_a;
  assign read_b       = rr.read_b;
  assign branch_or_jr = is_branch_or_jr(opcode, funct);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Pipeline sequencing controller: every cycle decides which pipeline
// registers advance, hold or take a bubble, for load-use hazards not covered
// by ID forwarding, taken branches/jumps resolved in ID, and variable-latency
// data-memory accesses in MEM. Priority: memory wait > load-use > flush.
//
// Parameters:
//   MEM_TIMEOUT  cycles a data-memory access may wait before mem_err is set
//   CNT_W        width of the stall performance counter
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ID_inst             instruction in ID
//   EXE_memread/_wraddr/_wr_en   load / destination info of EXE instruction
//   MEM_memread/_wraddr          load / destination info of MEM instruction
//   MEM_dmem_req        MEM instruction accesses data memory
//   dmem_ready          data memory completes the access this cycle
//   ID_branch_taken     BEQ/BNE in ID resolved taken
//   ID_jump             J/JAL/JR in ID
//   pc_en, IF_ID_en, IF_ID_flush, ID_EXE_flush, EXE_MEM_en, MEM_WB_flush
//                       combinational pipeline-register controls
//   stall_cycles        saturating count of cycles with pc_en low
//   mem_err             sticky memory-timeout flag
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ID_inst,
  input  logic             EXE_memread,
  input  logic [4:0]       EXE_wraddr,
  input  logic             EXE_wr_en,
  input  logic             MEM_memread,
  input  logic [4:0]       MEM_wraddr,
  input  logic             MEM_dmem_req,
  input  logic             dmem_ready,
  input  logic             ID_branch_taken,
  input  logic             ID_jump,
  output logic             pc_en,
  output logic             IF_ID_en,
  output logic             IF_ID_flush,
  output logic             ID_EXE_flush,
  output logic             EXE_MEM_en,
  output logic             MEM_WB_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_err
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  // The wait counter includes the cycle that first sees the access
  // not ready, so the MEM_TIMEOUT-th waiting cycle is the one where the
  // registered count equals MEM_TIMEOUT-1.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // ID decode and hazard detection
  // ---------------------------------------------------------------------------
  logic [4:0] read_a;
  logic [4:0] read_b;
  logic       branch_or_jr;

  id_read_decode u_id_read_decode (
    .ID_inst      (ID_inst),
    .read_a       (read_a),
    .read_b       (read_b),
    .branch_or_jr (branch_or_jr)
  );

  logic       haz_a;          // load in EXE feeds ID
  logic       haz_b;          // load in MEM feeds an ID-stage comparator
  logic [1:0] bubbles;
  logic       mem_not_ready;

  // Unread sources decode to $0 and a $0 destination is excluded, so an
  // unused register field can never raise a hazard.
  assign haz_a = EXE_memread && EXE_wr_en && (EXE_wraddr != 5'd0) &&
                 ((EXE_wraddr == read_a) || (EXE_wraddr == read_b));

  // An ALU consumer gets MEM-stage load data through forwarding; only
  // branches and JR, which need the value in ID, must wait for it.
  assign haz_b = MEM_memread && branch_or_jr && (MEM_wraddr != 5'd0) &&
                 ((MEM_wraddr == read_a) || (MEM_wraddr == read_b));

  always_comb begin
    if (haz_a)      bubbles = branch_or_jr ? 2'd2 : 2'd1;
    else if (haz_b) bubbles = 2'd1;
    else            bubbles = 2'd0;
  end

  assign mem_not_ready = MEM_dmem_req && !dmem_ready;

  // ---------------------------------------------------------------------------
  // Next state and pipeline controls
  // ---------------------------------------------------------------------------
  hz_state_e         state_q, state_d;
  logic [1:0]        bub_q, bub_d;     // bubbles still owed after this one
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_set;
  logic              do_wait;          // hold everything up to MEM
  logic              do_bubble;        // owed bubble of a load-use stall
  logic              do_run;           // evaluate hazards / flushes

  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    pc_en        = 1'b1;
    IF_ID_en     = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EXE_flush = 1'b0;
    EXE_MEM_en   = 1'b1;
    MEM_WB_flush = 1'b0;
    state_d      = state_q;
    bub_d        = bub_q;
    wait_d       = wait_q;
    err_set      = 1'b0;
    do_wait      = 1'b0;
    do_bubble    = 1'b0;
    do_run       = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_not_ready) begin
          do_wait = 1'b1;
          wait_d  = WAIT_W'(1);
        end else begin
          do_run = 1'b1;
        end
      end

      ST_BUBBLE: begin
        // bub_q is left untouched so the owed bubble resumes after the wait.
        if (mem_not_ready) begin
          do_wait = 1'b1;
          wait_d  = WAIT_W'(1);
        end else begin
          do_bubble = 1'b1;
        end
      end

      ST_MEMWAIT: begin
        if (mem_not_ready && (wait_q != WAIT_LAST)) begin
          do_wait = 1'b1;
          wait_d  = wait_q + WAIT_W'(1);
        end else begin
          // Access completed, or timed out: the pipeline moves on. A timed
          // out access is discarded by bubbling MEM/WB for this cycle.
          wait_d = '0;
          if (mem_not_ready) begin
            err_set      = 1'b1;
            MEM_WB_flush = 1'b1;
          end
          if (bub_q != 2'd0) do_bubble = 1'b1;
          else               do_run    = 1'b1;
        end
      end

      default: state_d = ST_RUN;
    endcase

    if (do_wait) begin
      // ID/EXE simply holds (no flush); MEM/WB gets bubbles until data arrives.
      pc_en        = 1'b0;
      IF_ID_en     = 1'b0;
      EXE_MEM_en   = 1'b0;
      MEM_WB_flush = 1'b1;
      state_d      = ST_MEMWAIT;
    end

    if (do_bubble) begin
      pc_en        = 1'b0;
      IF_ID_en     = 1'b0;
      ID_EXE_flush = 1'b1;
      bub_d        = (bub_q != 2'd0) ? bub_q - 2'd1 : 2'd0;
      state_d      = (bub_q > 2'd1) ? ST_BUBBLE : ST_RUN;
    end

    if (do_run) begin
      if (bubbles != 2'd0) begin
        // The branch outcome is not valid while ID stalls, so no flush here.
        pc_en        = 1'b0;
        IF_ID_en     = 1'b0;
        ID_EXE_flush = 1'b1;
        bub_d        = bubbles - 2'd1;
        state_d      = (bubbles == 2'd2) ? ST_BUBBLE : ST_RUN;
      end else begin
        IF_ID_flush = ID_branch_taken || ID_jump;
        state_d     = ST_RUN;
      end
    end

    // Reset drives every pipeline register to hold or bubble.
    if (rst) begin
      pc_en        = 1'b0;
      IF_ID_en     = 1'b0;
      EXE_MEM_en   = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EXE_flush = 1'b1;
      MEM_WB_flush = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State, counters and error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before this edge, independent of statement order.
    if (rst) begin
      state_q      <= ST_RUN;
      bub_q        <= 2'd0;
      wait_q       <= '0;
      stall_cycles <= '0;
      mem_err      <= 1'b0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      wait_q  <= wait_d;
      if (err_set) mem_err <= 1'b1;
      if (!pc_en && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed scoreboard bench: the driver applies one input vector per cycle
// and queues the hand-computed control outputs plus the expected counter and
// error flag; a monitor pops one entry each falling edge and compares.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam int CNT_W = 16;

  // Control vector order: {pc_en, IF_ID_en, IF_ID_flush, ID_EXE_flush,
  //                        EXE_MEM_en, MEM_WB_flush}
  localparam logic [5:0] C_NORM  = 6'b110010;
  localparam logic [5:0] C_BRFL  = 6'b111010;
  localparam logic [5:0] C_STALL = 6'b000110;
  localparam logic [5:0] C_WAIT  = 6'b000001;
  localparam logic [5:0] C_RST   = 6'b001101;
  localparam logic [5:0] C_TOUT  = 6'b110011;

  // Registers: $t0=8, $t1=9, $t2=10
  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_ADD  = {6'h00, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};  // add $t1,$t0,$t2
  localparam logic [31:0] I_ADD0 = {6'h00, 5'd0, 5'd0, 5'd9, 5'd0, 6'h20};   // add $t1,$0,$0
  localparam logic [31:0] I_BEQ  = {6'h04, 5'd8, 5'd9, 16'd4};               // beq $t0,$t1
  localparam logic [31:0] I_BNE  = {6'h05, 5'd9, 5'd8, 16'd3};               // bne $t1,$t0
  localparam logic [31:0] I_SLL  = {6'h00, 5'd8, 5'd10, 5'd9, 5'd2, 6'h00}; // sll $t1,$t2,2 (rs bits=$t0)
  localparam logic [31:0] I_ADDI = {6'h08, 5'd9, 5'd8, 16'd5};               // addi $t0,$t1,5
  localparam logic [31:0] I_J    = {6'h02, 26'h100_0000};                    // target bits[25:21]=$t0
  localparam logic [31:0] I_JR   = {6'h00, 5'd8, 15'd0, 6'h08};              // jr $t0

  typedef struct packed {
    logic [31:0] inst;
    logic        exe_ld;
    logic [4:0]  exe_rd;
    logic        exe_we;
    logic        mem_ld;
    logic [4:0]  mem_rd;
    logic        req;
    logic        rdy;
    logic        br;
    logic        jmp;
    logic        rst;
  } stim_t;

  typedef struct {
    string            tag;
    logic [5:0]       ctl;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      ID_inst;
  logic             EXE_memread, EXE_wr_en, MEM_memread, MEM_dmem_req, dmem_ready;
  logic [4:0]       EXE_wraddr, MEM_wraddr;
  logic             ID_branch_taken, ID_jump;
  logic             pc_en, IF_ID_en, IF_ID_flush, ID_EXE_flush, EXE_MEM_en, MEM_WB_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic             mem_err;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_errors = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic             exp_err = 1'b0;

  hazard_stall_ctrl #(.MEM_TIMEOUT(64), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .ID_inst         (ID_inst),
    .EXE_memread     (EXE_memread),
    .EXE_wraddr      (EXE_wraddr),
    .EXE_wr_en       (EXE_wr_en),
    .MEM_memread     (MEM_memread),
    .MEM_wraddr      (MEM_wraddr),
    .MEM_dmem_req    (MEM_dmem_req),
    .dmem_ready      (dmem_ready),
    .ID_branch_taken (ID_branch_taken),
    .ID_jump         (ID_jump),
    .pc_en           (pc_en),
    .IF_ID_en        (IF_ID_en),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EXE_flush    (ID_EXE_flush),
    .EXE_MEM_en      (EXE_MEM_en),
    .MEM_WB_flush    (MEM_WB_flush),
    .stall_cycles    (stall_cycles),
    .mem_err         (mem_err)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(
    input logic [31:0] inst,
    input logic exe_ld, input logic [4:0] exe_rd, input logic exe_we,
    input logic mem_ld, input logic [4:0] mem_rd,
    input logic req, input logic rdy,
    input logic br, input logic jmp, input logic r
  );
    stim_t s;
    s.inst = inst;   s.exe_ld = exe_ld; s.exe_rd = exe_rd; s.exe_we = exe_we;
    s.mem_ld = mem_ld; s.mem_rd = mem_rd; s.req = req; s.rdy = rdy;
    s.br = br; s.jmp = jmp; s.rst = r;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    ID_inst         = s.inst;
    EXE_memread     = s.exe_ld;
    EXE_wraddr      = s.exe_rd;
    EXE_wr_en       = s.exe_we;
    MEM_memread     = s.mem_ld;
    MEM_wraddr      = s.mem_rd;
    MEM_dmem_req    = s.req;
    dmem_ready      = s.rdy;
    ID_branch_taken = s.br;
    ID_jump         = s.jmp;
    rst             = s.rst;
  endtask

  // One cycle: drive inputs, queue expectation, advance past the edge and
  // update the expected registered values.
  task automatic step(input string tag, input stim_t s, input logic [5:0] ctl,
                      input bit set_err);
    exp_t e;
    drive(s);
    e.tag = tag; e.ctl = ctl; e.cnt = exp_stall; e.err = exp_err;
    sb.push_back(e);
    @(posedge clk);
    if (s.rst) begin
      exp_stall = '0;
      exp_err   = 1'b0;
    end else begin
      if (!ctl[5] && !(&exp_stall)) exp_stall = exp_stall + 1'b1;
      if (set_err) exp_err = 1'b1;
    end
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: the controller presents a result every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".ctl"}, 32'({pc_en, IF_ID_en, IF_ID_flush, ID_EXE_flush,
                                    EXE_MEM_en, MEM_WB_flush}), 32'(e.ctl));
        check({e.tag, ".stall_cycles"}, 32'(stall_cycles), 32'(e.cnt));
        check({e.tag, ".mem_err"}, 32'(mem_err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(mk(I_NOP, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    @(posedge clk);
    #1;

    step("reset",          mk(I_NOP,  0, 0, 0, 0, 0, 0, 1, 0, 0, 1), C_RST,   0);
    step("idle",           mk(I_NOP,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0), C_NORM,  0);
    // LW $t0 then ADD: one bubble
    step("lu_add",         mk(I_ADD,  1, 8, 1, 0, 0, 0, 1, 0, 0, 0), C_STALL, 0);
    step("lu_add_after",   mk(I_ADD,  0, 0, 0, 1, 8, 1, 1, 0, 0, 0), C_NORM,  0);
    // LW $t0 then BEQ: two bubbles then taken flush
    step("lu_beq_1",       mk(I_BEQ,  1, 8, 1, 0, 0, 0, 1, 0, 0, 0), C_STALL, 0);
    step("lu_beq_2",       mk(I_BEQ,  0, 0, 0, 1, 8, 1, 1, 0, 0, 0), C_STALL, 0);
    step("beq_taken",      mk(I_BEQ,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0), C_BRFL,  0);
    // Cases that must not stall
    step("sll_rs_unread",  mk(I_SLL,  1, 8, 1, 0, 0, 0, 1, 0, 0, 0), C_NORM,  0);
    step("lw_to_r0",       mk(I_ADD0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0), C_NORM,  0);
    step("exe_no_wr_en",   mk(I_ADD,  1, 8, 0, 0, 0, 0, 1, 0, 0, 0), C_NORM,  0);
    step("addi_rt_unread", mk(I_ADDI, 1, 8, 1, 0, 0, 0, 1, 0, 0, 0), C_NORM,  0);
    // Load in MEM feeding a branch: one bubble
    step("lu_mem_bne",     mk(I_BNE,  0, 0, 0, 1, 8, 1, 1, 0, 0, 0), C_STALL, 0);
    step("bne_not_taken",  mk(I_BNE,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0), C_NORM,  0);
    step("j_flush",        mk(I_J,    1, 8, 1, 0, 0, 0, 1, 0, 1, 0), C_BRFL,  0);
    // LW $t0 then JR $t0: two bubbles
    step("lu_jr_1",        mk(I_JR,   1, 8, 1, 0, 0, 0, 1, 0, 0, 0), C_STALL, 0);
    step("lu_jr_2",        mk(I_JR,   0, 0, 0, 1, 8, 1, 1, 0, 0, 0), C_STALL, 0);
    step("jr_flush",       mk(I_JR,   0, 0, 0, 0, 0, 0, 1, 0, 1, 0), C_BRFL,  0);
    // Three-cycle memory wait
    for (int i = 0; i < 3; i++)
      step("memwait3",     mk(I_ADD,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0), C_WAIT,  0);
    step("memwait3_done",  mk(I_ADD,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0), C_NORM,  0);
    // Memory wait during a two-bubble stall
    step("bw_stall",       mk(I_BEQ,  1, 8, 1, 0, 0, 0, 1, 0, 0, 0), C_STALL, 0);
    step("bw_wait_1",      mk(I_BEQ,  0, 0, 0, 1, 8, 1, 0, 0, 0, 0), C_WAIT,  0);
    step("bw_wait_2",      mk(I_BEQ,  0, 0, 0, 1, 8, 1, 0, 0, 0, 0), C_WAIT,  0);
    step("bw_resume",      mk(I_BEQ,  0, 0, 0, 1, 8, 1, 1, 0, 0, 0), C_STALL, 0);
    step("bw_taken",       mk(I_BEQ,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0), C_BRFL,  0);
    // Memory wait outranks a load-use hazard
    step("prio_wait",      mk(I_ADD,  1, 8, 1, 0, 0, 1, 0, 0, 0, 0), C_WAIT,  0);
    step("prio_lu",        mk(I_ADD,  1, 8, 1, 0, 0, 1, 1, 0, 0, 0), C_STALL, 0);
    step("prio_done",      mk(I_ADD,  0, 0, 0, 1, 8, 1, 1, 0, 0, 0), C_NORM,  0);
    // Reset while in BUBBLE
    step("rb_stall",       mk(I_BEQ,  1, 8, 1, 0, 0, 0, 1, 0, 0, 0), C_STALL, 0);
    step("rb_reset",       mk(I_BEQ,  0, 0, 0, 1, 8, 1, 1, 0, 0, 1), C_RST,   0);
    step("rb_run",         mk(I_ADD,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0), C_NORM,  0);
    // Memory timeout: 63 held cycles, release on the 64th
    for (int i = 0; i < 63; i++)
      step("timeout_wait", mk(I_ADD,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0), C_WAIT,  0);
    step("timeout_rel",    mk(I_ADD,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0), C_TOUT,  1);
    step("err_sticky_1",   mk(I_ADD,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0), C_NORM,  0);
    step("err_sticky_2",   mk(I_ADD,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0), C_NORM,  0);
    step("err_reset",      mk(I_ADD,  0, 0, 0, 0, 0, 0, 1, 0, 0, 1), C_RST,   0);
    step("err_cleared",    mk(I_ADD,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0), C_NORM,  0);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
